// File: rtl/spi_master_nslave_if.sv
// Bus bundle between the system controller and the SPI master.
//   master modport : the SPI master's view (requests in, status and SPI pins out)
//   slave  modport : the controller / SPI-bus side view (mirror of master)
// Signals:
//   tx_start, slave_sel, cpol, cpha, master_data_in : transfer request
//   master_data_out, busy, tx_done, rx_done, sel_err : status and result
//   sclk, mosi, miso, ss_n                           : SPI pins
interface spi_master_nslave_if #(
  parameter int unsigned DATA_W     = 10,
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned SEL_W      = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) ();
  logic                  tx_start;
  logic [SEL_W-1:0]      slave_sel;
  logic                  cpol;
  logic                  cpha;
  logic [DATA_W-1:0]     master_data_in;
  logic [DATA_W-1:0]     master_data_out;
  logic                  busy;
  logic                  tx_done;
  logic                  rx_done;
  logic                  sel_err;
  logic                  sclk;
  logic                  mosi;
  logic                  miso;
  logic [NUM_SLAVES-1:0] ss_n;

  modport master (
    input  tx_start, slave_sel, cpol, cpha, master_data_in, miso,
    output master_data_out, busy, tx_done, rx_done, sel_err, sclk, mosi, ss_n
  );

  modport slave (
    output tx_start, slave_sel, cpol, cpha, master_data_in, miso,
    input  master_data_out, busy, tx_done, rx_done, sel_err, sclk, mosi, ss_n
  );
endinterface

// File: rtl/spi_master_nslave.sv
// Parametrised SPI master: full-duplex, MSB-first transfers of DATA_W bits to one of
// NUM_SLAVES active-low selects, per-transfer CPOL/CPHA, SCLK half-period = CLK_DIV clks.
// Ports:
//   clk     : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : spi_master_nslave_if.master (request, status and SPI pins)
// A transfer spans 2*DATA_W+2 half-periods: SETUP, 2*DATA_W SCLK edges (the first one
// ends SETUP), one idle half-period after the last edge, then HOLD.
module spi_master_nslave #(
  parameter int unsigned DATA_W     = 10,
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned SEL_W      = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
  input logic                 clk,
  input logic                 reset_n,
  spi_master_nslave_if.master bus
);
  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BitW = $clog2(DATA_W + 1);
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [BitW-1:0] BitInit = BitW'(DATA_W);

  typedef enum logic [1:0] {StIdle, StSetup, StShift, StHold} state_e;

  state_e            state_q, state_d;
  logic [DivW-1:0]   div_q, div_d;
  logic [BitW-1:0]   bit_q, bit_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              cpol_q, cpol_d;
  logic              cpha_q, cpha_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              done_q, done_d;
  logic              sel_err_q, sel_err_d;

  logic                  sel_bad;
  logic                  div_wrap;
  logic                  leading;
  logic                  edge_en;
  logic [NUM_SLAVES-1:0] ss_n_w;

  assign sel_bad  = (32'(bus.slave_sel) >= NUM_SLAVES);
  assign div_wrap = (div_q == DivLast);
  // The next SCLK edge is a leading one while SCLK still sits at its idle level.
  assign leading  = (sclk_q == cpol_q);

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bit_d     = bit_q;
    sel_d     = sel_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    rdata_d   = rdata_q;
    done_d    = 1'b0;
    sel_err_d = 1'b0;
    edge_en   = 1'b0;

    unique case (state_q)
      StIdle: begin
        mosi_d = 1'b0;
        if (bus.tx_start) begin
          if (sel_bad) begin
            sel_err_d = 1'b1;
          end else begin
            state_d = StSetup;
            sel_d   = bus.slave_sel;
            cpol_d  = bus.cpol;
            cpha_d  = bus.cpha;
            sclk_d  = bus.cpol;
            div_d   = '0;
            bit_d   = BitInit;
            rx_d    = '0;
            if (!bus.cpha) begin
              // Mode with cpha=0 presents the MSB before the first edge.
              mosi_d = bus.master_data_in[DATA_W-1];
              tx_d   = {bus.master_data_in[DATA_W-2:0], 1'b0};
            end else begin
              mosi_d = 1'b0;
              tx_d   = bus.master_data_in;
            end
          end
        end
      end
      StSetup: begin
        div_d = div_wrap ? '0 : div_q + 1'b1;
        if (div_wrap) begin
          edge_en = 1'b1;
          state_d = StShift;
        end
      end
      StShift: begin
        div_d = div_wrap ? '0 : div_q + 1'b1;
        if (div_wrap) begin
          // bit_q reaches 0 on the last trailing edge; the following half-period is idle.
          if (bit_q == '0) begin
            state_d = StHold;
          end else begin
            edge_en = 1'b1;
          end
        end
      end
      StHold: begin
        div_d = div_wrap ? '0 : div_q + 1'b1;
        if (div_wrap) begin
          state_d = StIdle;
          done_d  = 1'b1;
          rdata_d = rx_q;
          mosi_d  = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (edge_en) begin
      sclk_d = ~sclk_q;
      if (!leading) begin
        bit_d = bit_q - 1'b1;
      end
      // Drive on leading edges for cpha=1, on trailing edges for cpha=0; sample on the other.
      if (leading == cpha_q) begin
        mosi_d = tx_q[DATA_W-1];
        tx_d   = {tx_q[DATA_W-2:0], 1'b0};
      end else begin
        rx_d = {rx_q[DATA_W-2:0], bus.miso};
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      div_q     <= '0;
      bit_q     <= '0;
      sel_q     <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      tx_q      <= '0;
      rx_q      <= '0;
      rdata_q   <= '0;
      done_q    <= 1'b0;
      sel_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      sel_q     <= sel_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rdata_q   <= rdata_d;
      done_q    <= done_d;
      sel_err_q <= sel_err_d;
    end
  end

  // Selects decode straight from state so an asynchronous reset releases them at once.
  always_comb begin
    ss_n_w = '1;
    if (state_q != StIdle) begin
      for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
        if (32'(sel_q) == i) begin
          ss_n_w[i] = 1'b0;
        end
      end
    end
  end

  assign bus.ss_n            = ss_n_w;
  assign bus.busy            = (state_q != StIdle);
  assign bus.sclk            = sclk_q;
  assign bus.mosi            = mosi_q;
  assign bus.master_data_out = rdata_q;
  assign bus.tx_done         = done_q;
  assign bus.rx_done         = done_q;
  assign bus.sel_err         = sel_err_q;
endmodule

// File: tb/tb_spi_master_nslave.sv
// Directed bench for spi_master_nslave (DATA_W=10, NUM_SLAVES=4, CLK_DIV=4, SEL_W=3 so
// out-of-range selects can be presented). A behavioural SPI slave lives in the stimulus task.
module tb_spi_master_nslave;
  localparam int unsigned DW   = 10;
  localparam int unsigned NS   = 4;
  localparam int unsigned DIV  = 4;
  localparam int          TLEN = DIV * (2 * DW + 2);

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  spi_master_nslave_if #(.DATA_W(DW), .NUM_SLAVES(NS), .SEL_W(3)) bus ();

  spi_master_nslave #(
    .DATA_W     (DW),
    .NUM_SLAVES (NS),
    .CLK_DIV    (DIV),
    .SEL_W      (3)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Caller sits just after a negedge. Returns at the negedge of the done cycle.
  task automatic do_xfer(input string tag, input int sel, input bit pol, input bit pha,
                         input logic [DW-1:0] mdata, input logic [DW-1:0] sword,
                         input bit hold);
    logic [DW-1:0]     s_sh;
    logic [DW-1:0]     s_rx;
    logic [NS-1:0]     exp_ss;
    logic              prev_sclk;
    logic              lead;
    logic              exp_sclk;
    int                n;
    int                done_cyc;
    int                ss_bad, busy_bad, sclk_bad, err_bad;
    ss_bad = 0; busy_bad = 0; sclk_bad = 0; err_bad = 0; done_cyc = -1;
    exp_ss = ~(NS'(1) << sel);
    bus.slave_sel      = 3'(sel);
    bus.cpol           = pol;
    bus.cpha           = pha;
    bus.master_data_in = mdata;
    bus.tx_start       = 1'b1;
    @(posedge clk);
    #1;
    // Scramble inputs; the latched copies must carry the transfer.
    if (!hold) bus.tx_start = 1'b0;
    bus.slave_sel      = 3'd5;
    bus.cpol           = ~pol;
    bus.cpha           = ~pha;
    bus.master_data_in = ~mdata;
    s_rx = '0;
    if (!pha) begin
      bus.miso = sword[DW-1];
      s_sh     = sword << 1;
    end else begin
      bus.miso = 1'b0;
      s_sh     = sword;
    end
    prev_sclk = bus.sclk;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk);
      if (bus.tx_done) begin
        done_cyc = cyc;
        break;
      end
      if (bus.ss_n !== exp_ss) ss_bad++;
      if (bus.busy !== 1'b1) busy_bad++;
      if (bus.sel_err !== 1'b0) err_bad++;
      n = (cyc - 1) / DIV;
      if (n > 2 * DW) n = 2 * DW;
      exp_sclk = pol ^ n[0];
      if (bus.sclk !== exp_sclk) sclk_bad++;
      @(posedge clk);
      #1;
      if (bus.sclk !== prev_sclk) begin
        lead = (bus.sclk != pol);
        if (lead != pha) begin
          s_rx = {s_rx[DW-2:0], bus.mosi};
        end else begin
          bus.miso = s_sh[DW-1];
          s_sh     = s_sh << 1;
        end
        prev_sclk = bus.sclk;
      end
    end
    check($sformatf("%s done_cycle", tag), 32'(done_cyc), 32'(TLEN + 1));
    check($sformatf("%s rx_done", tag), 32'(bus.rx_done), 32'd1);
    check($sformatf("%s busy_at_done", tag), 32'(bus.busy), 32'd0);
    check($sformatf("%s ss_n_at_done", tag), 32'(bus.ss_n), 32'hF);
    check($sformatf("%s data_out", tag), 32'(bus.master_data_out), 32'(sword));
    check($sformatf("%s slave_rx", tag), 32'(s_rx), 32'(mdata));
    check($sformatf("%s ss_n_cycles_bad", tag), 32'(ss_bad), 32'd0);
    check($sformatf("%s busy_cycles_bad", tag), 32'(busy_bad), 32'd0);
    check($sformatf("%s sclk_cycles_bad", tag), 32'(sclk_bad), 32'd0);
    check($sformatf("%s sel_err_while_busy", tag), 32'(err_bad), 32'd0);
  endtask

  logic [DW-1:0] words [4];
  int            pulses;

  initial begin
    checks = 0;
    errors = 0;
    words[0] = 10'b0011011010;
    words[1] = 10'b1011011001;
    words[2] = 10'b1010110111;
    words[3] = 10'b0001101110;
    reset_n            = 1'b0;
    bus.tx_start       = 1'b0;
    bus.slave_sel      = '0;
    bus.cpol           = 1'b0;
    bus.cpha           = 1'b0;
    bus.master_data_in = '0;
    bus.miso           = 1'b0;
    repeat (3) @(negedge clk);
    check("rst ss_n", 32'(bus.ss_n), 32'hF);
    check("rst sclk", 32'(bus.sclk), 32'd0);
    check("rst mosi", 32'(bus.mosi), 32'd0);
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst pulses", 32'({bus.tx_done, bus.rx_done, bus.sel_err}), 32'd0);
    check("rst data_out", 32'(bus.master_data_out), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    do_xfer("t1", 1, 1'b0, 1'b0, 10'b1010101100, 10'b0011011010, 1'b0);
    @(negedge clk);
    check("t1 done_pulse_width", 32'({bus.tx_done, bus.rx_done}), 32'd0);
    check("t1 data_out_hold", 32'(bus.master_data_out), 32'(10'b0011011010));

    for (int s = 0; s < 4; s++) begin
      do_xfer($sformatf("t2_sel%0d", s), s, 1'b0, 1'b0, ~words[s], words[s], 1'b0);
      @(negedge clk);
    end

    for (int m = 0; m < 4; m++) begin
      do_xfer($sformatf("t3_mode%0d", m), 0, m[1], m[0], 10'h2A5, 10'h2A5, 1'b0);
      @(negedge clk);
      check($sformatf("t3_mode%0d sclk_idle", m), 32'(bus.sclk), 32'(m[1]));
    end

    // Held start: no restart mid-transfer, then back-to-back from the done cycle.
    do_xfer("t4a", 2, 1'b0, 1'b0, 10'h155, 10'h0F3, 1'b1);
    do_xfer("t4b", 3, 1'b1, 1'b1, 10'h3C1, 10'h1A6, 1'b0);
    @(negedge clk);

    for (int k = 0; k < 2; k++) begin
      bus.slave_sel = (k == 0) ? 3'd4 : 3'd7;
      bus.tx_start  = 1'b1;
      @(posedge clk);
      #1;
      bus.tx_start = 1'b0;
      @(negedge clk);
      check($sformatf("t5_%0d sel_err", k), 32'(bus.sel_err), 32'd1);
      check($sformatf("t5_%0d busy", k), 32'(bus.busy), 32'd0);
      check($sformatf("t5_%0d ss_n", k), 32'(bus.ss_n), 32'hF);
      @(negedge clk);
      check($sformatf("t5_%0d sel_err_width", k), 32'(bus.sel_err), 32'd0);
      check($sformatf("t5_%0d busy_after", k), 32'(bus.busy), 32'd0);
    end

    // Reset in cycle 40 of a transfer (cpol=1 so sclk must be forced back to 0).
    bus.slave_sel      = 3'd2;
    bus.cpol           = 1'b1;
    bus.cpha           = 1'b0;
    bus.master_data_in = 10'h3FF;
    bus.tx_start       = 1'b1;
    @(posedge clk);
    #1;
    bus.tx_start = 1'b0;
    repeat (40) @(negedge clk);
    check("t6 busy_before", 32'(bus.busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check("t6 ss_n", 32'(bus.ss_n), 32'hF);
    check("t6 sclk", 32'(bus.sclk), 32'd0);
    check("t6 busy", 32'(bus.busy), 32'd0);
    check("t6 data_out", 32'(bus.master_data_out), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus.tx_done || bus.rx_done) pulses++;
    end
    check("t6 done_pulses", 32'(pulses), 32'd0);
    check("t6 busy_after", 32'(bus.busy), 32'd0);
    check("t6 data_out_after", 32'(bus.master_data_out), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_master_nslave.md
Name: spi_master_nslave

Overview:
Parametrised SPI master that drives one of NUM_SLAVES slave-select lines and performs full-duplex, MSB-first transfers of DATA_W bits. The SCLK rate is programmable through a clock divider. Mode (CPOL/CPHA) is selected per transfer. It succeeds the fixed 4-slave, 10-bit, mode-0-only master and sits between the system controller and the off-block SPI slave bus.

Parameters:
DATA_W, 10, transfer word width in bits (>=2)
NUM_SLAVES, 4, number of slave-select outputs (>=1)
CLK_DIV, 4, clk cycles per SCLK half-period (>=2)
SEL_W, $clog2(NUM_SLAVES) (min 1), width of slave_sel

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
tx_start  in  1  start request, sampled only in IDLE
slave_sel  in  SEL_W  target slave index, latched with tx_start
cpol  in  1  SCLK idle level, latched with tx_start
cpha  in  1  0: sample leading edge; 1: sample trailing edge; latched with tx_start
master_data_in  in  DATA_W  transmit word, latched with tx_start
master_data_out  out  DATA_W  last received word
busy  out  1  high from acceptance until done pulse
tx_done  out  1  one-cycle pulse, transmit complete
rx_done  out  1  one-cycle pulse, master_data_out valid
sel_err  out  1  one-cycle pulse, tx_start rejected (slave_sel >= NUM_SLAVES)
sclk  out  1  SPI clock
mosi  out  1  serial data out
miso  in  1  serial data in (shared slave bus)
ss_n  out  NUM_SLAVES  active-low slave selects, one-hot-low when active

Behaviour:
- Reset (async, reset_n=0): state=IDLE, ss_n all 1, sclk=0, mosi=0, busy=0, tx_done=rx_done=sel_err=0, master_data_out=0, latched cpol=0. Reset mid-transfer aborts immediately. No done pulse is issued.
- States: IDLE -> SETUP -> SHIFT -> HOLD -> IDLE.
- IDLE: sclk=latched cpol, mosi=0. On tx_start=1:
  - If slave_sel >= NUM_SLAVES: sel_err pulses next cycle, and the block stays IDLE.
  - Otherwise: latch data/sel/cpol/cpha, go to SETUP, busy=1.
- Timing, with cycle 0 = acceptance edge, T = CLK_DIV*(2*DATA_W+2):
  - ss_n[sel] is low in cycles 1..T.
  - SETUP occupies cycles 1..CLK_DIV. When cpha=0, mosi = bit DATA_W-1 from cycle 1.
  - SHIFT produces 2*DATA_W SCLK edges, one every CLK_DIV cycles. The first edge (leading, away from cpol) occurs at the end of cycle CLK_DIV.
  - cpha=0: sample miso on leading edges; update mosi to the next bit on trailing edges.
  - cpha=1: update mosi on leading edges (first leading edge drives the MSB); sample miso on trailing edges.
  - After the final edge, sclk=cpol. HOLD lasts CLK_DIV cycles.
  - Cycle T+1: ss_n all 1, state=IDLE, busy=0, master_data_out = received word (first sampled bit = MSB), tx_done=rx_done=1 for exactly one cycle.
- tx_start while busy: ignored, with no queuing and no sel_err.
- tx_start in cycle T+1 (the done-pulse cycle): accepted, giving back-to-back transfers. ss_n rises for at least one cycle between transfers.
- Changes to inputs during a transfer have no effect; all transfer inputs are latched at acceptance.
- master_data_out holds its value until the next rx_done.
- Counters: the bit counter counts DATA_W down to 0. The divider counter wraps 0..CLK_DIV-1. Neither may wrap past terminal.

Test Plan:
1. Mode 0, CLK_DIV=4, sel=1, master_data_in=10'b1010101100; slave model returns 10'b0011011010 -> ss_n=4'b1101 in cycles 1..88. mosi sampled on rising sclk reads 1010101100 in order. Done pulses at cycle 89 with master_data_out=10'b0011011010.
2. Four sequential transfers to sel 0..3 with slave words 0011011010, 1011011001, 1010110111, 0001101110 -> each master_data_out matches its slave word. Only the addressed ss_n bit goes low. All others stay 1.
3. All four modes (cpol/cpha = 00, 01, 10, 11), data 10'h2A5 in both directions -> sclk idles at cpol. Data is captured correctly in every mode. The done cycle is identical (89) for every mode.
4. tx_start held high for the whole transfer, then reasserted in the done cycle -> no restart mid-transfer. The second transfer starts at cycle 89, its ss_n falls at cycle 90, and ss_n is 1 at cycle 89.
5. slave_sel=4 with NUM_SLAVES=4 -> sel_err pulses one cycle. busy stays 0 and ss_n stays 4'b1111.
6. reset_n pulsed low at cycle 40 of a transfer -> within the same cycle ss_n=4'b1111, sclk=0, busy=0. No tx_done or rx_done pulse, and master_data_out=0.
